// File: rtl/cover_pkg.sv
// Shared types for the toggle-cover collector: global index type and readout FSM states.
package cover_pkg;
  localparam int COVER_IDX_W = 64;
  typedef logic [COVER_IDX_W-1:0] cover_idx_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} cover_dump_state_t;
endpackage

// File: rtl/cover_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest 1 in vec and an any-set flag.
module cover_prio_enc #(
  parameter int WIDTH = 64,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             any
);
  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cover_toggle_collector.sv
// Sticky toggle-cover hit bitmap with covered count and valid/ready readout of global hit indices.
// Optional macro COVER_TOGGLE_CLEAR_ON_DUMP_EN: accepted transfers also clear the hit bit.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int         WIDTH       = 64,
  parameter cover_idx_t COVER_INDEX = '0,
  parameter int         COVER_TOTAL = 9715,
  localparam int        CW          = $clog2(WIDTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       valid,
  input  logic                   dump_start,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COVER_IDX_W-1:0] out_index,
  output logic                   dump_done,
  output logic [CW-1:0]          covered_count,
  output logic                   busy
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if ((WIDTH < 1) || (WIDTH > 64)) begin : g_width_chk
    $error("cover_toggle_collector: WIDTH must be 1..64");
  end
  if (COVER_INDEX + cover_idx_t'(WIDTH) > cover_idx_t'(COVER_TOTAL)) begin : g_bounds_chk
    $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
  end

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Handshake: a beat transfers on a clock edge where out_valid && out_ready; while
  // out_ready is low, out_valid stays high and out_index holds its value.
  cover_dump_state_t state_q, state_d;
  logic [WIDTH-1:0]  hit_q, hit_d;
  logic [WIDTH-1:0]  snap_q, snap_d;
  logic [CW-1:0]     count_q, count_d;

  logic [IW-1:0]     enc_idx;
  logic              enc_any;
  logic [WIDTH-1:0]  cur_onehot;
  logic [WIDTH-1:0]  snap_clr;
  logic [WIDTH-1:0]  hit_now;
  logic              accept;

  cover_prio_enc #(.WIDTH(WIDTH)) u_enc (
    .vec(snap_q),
    .idx(enc_idx),
    .any(enc_any)
  );

  always_comb begin
    cur_onehot = WIDTH'(1) << enc_idx;
    snap_clr   = snap_q & ~cur_onehot;
    hit_now    = hit_q | valid;
    accept     = out_valid && out_ready;

`ifdef COVER_TOGGLE_CLEAR_ON_DUMP_EN
    // A same-cycle re-hit of the drained bit wins over the clear.
    hit_d = (hit_q & ~(accept ? cur_onehot : '0)) | valid;
`else
    hit_d = hit_now;
`endif
    count_d = popcount(hit_d);

    state_d = state_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          snap_d  = hit_now;
          state_d = (hit_now != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (accept) begin
          snap_d = snap_clr;
          if (snap_clr == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hit_q   <= '0;
      snap_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      snap_q  <= snap_d;
      count_q <= count_d;
    end
  end

  // Outputs decode straight from flops so an async reset drops them immediately.
  assign out_valid     = (state_q == SCAN) && enc_any;
  assign out_index     = out_valid ? (COVER_INDEX + cover_idx_t'(enc_idx)) : '0;
  assign dump_done     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign covered_count = count_q;
endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector: expected indices are queued at dump_start from a
// reference hit bitmap and popped on every accepted beat.
module tb_cover_toggle_collector;
  localparam int         WIDTH = 64;
  localparam logic [63:0] CIDX = 64'd100;
  localparam logic [63:0] HITS3 = 64'h8000_0000_0000_0021;

  logic              clock;
  logic              reset;
  logic [WIDTH-1:0]  valid;
  logic              dump_start;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_index;
  logic              dump_done;
  logic [6:0]        covered_count;
  logic              busy;

  cover_toggle_collector #(
    .WIDTH(WIDTH),
    .COVER_INDEX(CIDX),
    .COVER_TOTAL(9715)
  ) dut (
    .clock(clock),
    .reset(reset),
    .valid(valid),
    .dump_start(dump_start),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .dump_done(dump_done),
    .covered_count(covered_count),
    .busy(busy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model;

  function automatic logic [63:0] popcnt(input logic [63:0] v);
    logic [63:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 64'(v[i]);
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one-cycle hit strobe, then check the registered count
  task automatic hit(input logic [63:0] m);
    @(negedge clock);
    valid = m;
    model = model | m;
    @(negedge clock);
    valid = '0;
    check("count_after_hit", 64'(covered_count), popcnt(model));
  endtask

  // driver + scoreboard for one dump
  task automatic run_dump(input int stall_beat, input int stall_len, input int inject_bit,
                          input bit restart);
    int   n, obs, beats, stall_cnt;
    bit   done, rdy;
    logic [63:0] e;
    @(negedge clock);
    exp_q.delete();
    for (int i = 0; i < WIDTH; i++) if (model[i]) exp_q.push_back(CIDX + 64'(i));
    n = exp_q.size();
    dump_start = 1'b1;
    out_ready  = 1'b1;
    obs = 0; beats = 0; stall_cnt = 0; done = 1'b0;
    while (!done && obs < 200) begin
      @(negedge clock);
      obs++;
      dump_start = restart && (obs == 1);
      valid = '0;
      if (inject_bit >= 0 && obs == 1) begin
        valid[inject_bit] = 1'b1;
        model[inject_bit] = 1'b1;
      end
      if (dump_done) begin
        done = 1'b1;
        check("valid_low_at_done", 64'(out_valid), 64'd0);
      end else begin
        check("busy_in_dump", 64'(busy), 64'd1);
        check("scan_valid", 64'(out_valid), 64'd1);
        if (out_valid) begin
          rdy = !(beats == stall_beat && stall_cnt < stall_len);
          out_ready = rdy;
          if (exp_q.size() == 0) begin
            check("extra_beat", 64'(out_valid), 64'd0);
          end else if (rdy) begin
            e = exp_q.pop_front();
            check("out_index", out_index, e);
            beats++;
`ifdef COVER_TOGGLE_CLEAR_ON_DUMP_EN
            if (!(inject_bit >= 0 && obs == 1 && int'(e - CIDX) == inject_bit))
              model[int'(e - CIDX)] = 1'b0;
`endif
          end else begin
            stall_cnt++;
            check("held_index", out_index, exp_q[0]);
          end
        end
      end
    end
    valid      = '0;
    dump_start = 1'b0;
    out_ready  = 1'b1;
    check("dump_done_seen", 64'(done), 64'd1);
    check("dump_cycles", 64'(obs), 64'(n + 1 + ((stall_beat < n) ? stall_len : 0)));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
    check("done_one_cycle", 64'(dump_done), 64'd0);
    check("idle_after_dump", 64'(busy), 64'd0);
    check("count_after_dump", 64'(covered_count), popcnt(model));
  endtask

  initial begin
    reset      = 1'b1;
    valid      = '0;
    dump_start = 1'b0;
    out_ready  = 1'b1;
    model      = '0;
    repeat (2) @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(covered_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(dump_done), 64'd0);
    check("rst_index", out_index, 64'd0);
    reset = 1'b0;

    // empty dump: done on the 2nd cycle, no beats
    run_dump(99, 0, -1, 1'b0);

    // count tracks first hits only
    hit(64'h1);
    check("t1_count_1", 64'(covered_count), 64'd1);
    hit(64'h8000_0000_0000_0001);
    check("t1_count_2", 64'(covered_count), 64'd2);
    hit(64'h8000_0000_0000_0001);
    check("t1_count_repeat", 64'(covered_count), 64'd2);

    // hits {0,5,63}: 100,105,163 back to back; a restart pulse during SCAN is ignored
    hit(64'h20);
    run_dump(99, 0, -1, 1'b1);

    // stall 3 cycles on the 2nd beat
    hit(HITS3);
    run_dump(1, 3, -1, 1'b0);

    // bit 7 hit mid-scan shows up only in the following dump
    hit(HITS3);
    run_dump(99, 0, 7, 1'b0);
    run_dump(99, 0, -1, 1'b0);
`ifdef COVER_TOGGLE_CLEAR_ON_DUMP_EN
    check("clear_count_zero", 64'(covered_count), 64'd0);
`else
    check("sticky_count", 64'(covered_count), 64'd4);
`endif

    // async reset mid-scan
    hit(HITS3);
    @(negedge clock);
    dump_start = 1'b1;
    out_ready  = 1'b0;
    @(negedge clock);
    dump_start = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_index", out_index, CIDX);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_count", 64'(covered_count), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(dump_done), 64'd0);
    model = '0;
    @(negedge clock);
    reset     = 1'b0;
    out_ready = 1'b1;
    run_dump(99, 0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
